seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
- Time-shares the 8-digit seven-segment decoder between NREQ message sources and a background value.
- Drives the decoder's 32-bit hex word and display-enable input. Each source hands over a message with a valid/ready handshake; the message is shown for a requested number of ticks.
- Requesters are granted round-robin. The display returns to the background value when no message is active.
- Sits between the piano control logic (note, score, mode sources) and the seven-segment decoder.

Parameters:
- NREQ, 4, number of message requesters (2..8).
- TICK_DIV, 25000000, clk cycles per dwell tick (≥2).
- GAP_CYCLES, 4, blank cycles inserted between consecutive messages (0 disables the gap).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- bg_value  in  32  background hex word shown when idle
- bg_on  in  1  display enable while idle
- req_valid  in  NREQ  requester i has a message pending
- req_value  in  32*NREQ  message word; slice i is [32*i+31:32*i]
- req_dwell  in  8*NREQ  dwell in ticks; slice i is [8*i+7:8*i]; 0 treated as 1
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i]&&req_ready[i] at a clk edge
- disp_value  out  32  to decoder hex input
- disp_on  out  1  to decoder display enable
- busy  out  1  high in SHOW or GAP
- cur_owner  out  3  index of requester being shown; 0 when idle

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr pointer=0, prescaler=0, tick counter=0, latched word=0.
  - Outputs: disp_value=bg_value (combinational pass-through), disp_on=bg_on, req_ready=0, busy=0, cur_owner=0.
- States: IDLE, SHOW, GAP.
- IDLE:
  - disp_value=bg_value, disp_on=bg_on.
  - req_ready is combinational: one-hot on the first valid requester at or after the rr pointer, scanning upward with wrap. All zero if no request is valid.
  - On a transfer:
    - latch req_value[i] and the dwell (0→1);
    - set cur_owner=i and rr pointer=(i+1) mod NREQ;
    - clear the prescaler and go to SHOW.
  - The next cycle shows the message: 1-cycle latency from the accept edge.
- SHOW:
  - disp_value=latched word, disp_on=1, req_ready=0.
  - The prescaler counts 0..TICK_DIV-1; at wrap, the remaining count decrements.
  - When the remaining count reaches 0 at a wrap, go to GAP if GAP_CYCLES>0, else to IDLE.
  - Total SHOW duration is exactly dwell*TICK_DIV cycles.
- GAP:
  - disp_on=0, disp_value=latched word, req_ready=0.
  - After GAP_CYCLES cycles, go to IDLE.
  - Arbitration resumes in the first IDLE cycle, so back-to-back messages are separated by GAP_CYCLES+1 cycles.
- Requests:
  - Deasserting req_valid before ready is legal; nothing is latched.
  - req_value changes while a message is shown have no effect.
- Simultaneous requests: only one grant per IDLE cycle. The rr pointer guarantees each valid requester is served within NREQ messages.
- bg_value/bg_on changes take effect in the same cycle while IDLE.
- Widths: the remaining-ticks counter is 8 bits and the prescaler is $clog2(TICK_DIV) bits, with no overflow by construction.
- cur_owner is zero-extended to 3 bits.

Optional Feature:
- Macro SEG_ARB_BLINK_EN.
- When defined: during the final 2 ticks of SHOW (remaining ≤2), disp_on = (prescaler < TICK_DIV/2). This blinks the display as an end-of-message warning. Messages with dwell ≤2 blink for their whole duration.
- When undefined: disp_on=1 throughout SHOW. No extra logic is generated.

Decomposition:
- Shared package seg_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_SHOW=2'd1, ST_GAP=2'd2;
  - DWELL_W=8;
  - the display-word width constant 32.
- One natural sub-module, rr_arbiter_onehot:
  - parameterised by NREQ;
  - inputs req vector and pointer;
  - outputs one-hot grant and encoded index.

Test Plan (TICK_DIV=4, GAP_CYCLES=2, NREQ=4):
- Reset: rst_n=0 mid-SHOW → same-cycle return to IDLE, disp_value=bg_value, req_ready=0, busy=0.
- Single request: req_valid[2]=1, value 32'h0000_1234, dwell=3 → ready[2] for 1 cycle, then disp_value=0000_1234 and disp_on=1 for 12 cycles, 2 blank cycles, then background.
- Dwell zero: dwell=0 on requester 1 → message shown for exactly 4 cycles.
- Round robin: all four valid continuously, dwell=1 → grant order 0,1,2,3,0, each message 4 cycles with 3-cycle spacing.
- Late withdrawal: req_valid[3] pulsed only during SHOW of requester 0 → never granted, no latch.
- Blink (SEG_ARB_BLINK_EN defined): dwell=4 → disp_on is 1 for ticks 1–2, then the pattern 1,1,0,0 for ticks 3–4. Undefined → constant 1.

Source files
------------

// File: rtl/seg_arb_pkg.sv
// Shared constants and types for the seven-segment display arbiter.
package seg_arb_pkg;

  localparam int WORD_W  = 32;
  localparam int DWELL_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  // A requested dwell of zero still shows the message for one tick.
  function automatic logic [DWELL_W-1:0] fix_dwell(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// scanning upward with wrap. Produces a one-hot grant and its encoded index.
module rr_arbiter_onehot #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W:0] cand;

  // Walk the requesters starting at ptr and keep only the first hit.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NREQ)) begin
        cand = cand - (IDX_W+1)'(NREQ);
      end
      if (!grant_valid && req[cand[IDX_W-1:0]]) begin
        grant_valid               = 1'b1;
        grant_idx                 = cand[IDX_W-1:0];
        grant[cand[IDX_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Time-shares the 8-digit seven-segment decoder between NREQ message sources
// and a background word. Each accepted message is shown for dwell*TICK_DIV
// cycles, followed by GAP_CYCLES blank cycles, then the background returns.
// Optional build macro SEG_ARB_BLINK_EN: blink the display during the last
// two ticks of every message as an end-of-message warning.
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int TICK_DIV   = 25000000,
  parameter int GAP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_W-1:0]    bg_value,
  input  logic                 bg_on,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [WORD_W*NREQ-1:0] req_value,
  input  logic [DWELL_W*NREQ-1:0] req_dwell,
  output logic [NREQ-1:0]      req_ready,
  output logic [WORD_W-1:0]    disp_value,
  output logic                 disp_on,
  output logic                 busy,
  output logic [2:0]           cur_owner
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [PRE_W-1:0]   prescaler;
  logic [DWELL_W-1:0] remaining;
  logic [WORD_W-1:0]  word_q;
  logic [GAP_W-1:0]   gap_cnt;

  logic [NREQ-1:0]    grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic [WORD_W-1:0]  sel_value;
  logic [DWELL_W-1:0] sel_dwell;
  logic [IDX_W-1:0]   next_ptr;
  logic               pre_wrap;
  logic               show_on;

  rr_arbiter_onehot #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Pick the winning requester's message word and dwell out of the flat buses.
  always_comb begin
    sel_value = '0;
    sel_dwell = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_value = req_value[WORD_W*i +: WORD_W];
        sel_dwell = req_dwell[DWELL_W*i +: DWELL_W];
      end
    end
  end

  assign next_ptr = (grant_idx == IDX_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
  assign pre_wrap = (prescaler == PRE_W'(TICK_DIV-1));

`ifdef SEG_ARB_BLINK_EN
  assign show_on = (remaining <= DWELL_W'(2)) ? (prescaler < PRE_W'(TICK_DIV/2)) : 1'b1;
`else
  assign show_on = 1'b1;
`endif

  // Main sequencer: accept in IDLE, count ticks in SHOW, blank in GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      prescaler <= '0;
      remaining <= '0;
      word_q    <= '0;
      gap_cnt   <= '0;
      cur_owner <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            word_q    <= sel_value;
            remaining <= fix_dwell(sel_dwell);
            cur_owner <= 3'(grant_idx);
            rr_ptr    <= next_ptr;
            prescaler <= '0;
            state     <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (pre_wrap) begin
            prescaler <= '0;
            remaining <= remaining - 1'b1;
            if (remaining == DWELL_W'(1)) begin
              if (GAP_CYCLES > 0) begin
                gap_cnt <= '0;
                state   <= ST_GAP;
              end else begin
                cur_owner <= '0;
                state     <= ST_IDLE;
              end
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES-1)) begin
            cur_owner <= '0;
            state     <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Decoder drive: background while idle, latched word otherwise.
  always_comb begin
    disp_value = bg_value;
    disp_on    = bg_on;
    req_ready  = '0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = grant & {NREQ{rst_n}};
      end
      ST_SHOW: begin
        disp_value = word_q;
        disp_on    = show_on;
        busy       = 1'b1;
      end
      ST_GAP: begin
        disp_value = word_q;
        disp_on    = 1'b0;
        busy       = 1'b1;
      end
      default: begin
        disp_value = bg_value;
      end
    endcase
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed testbench for seg_display_arbiter with TICK_DIV=4, GAP_CYCLES=2, NREQ=4.
module tb_seg_display_arbiter;

  localparam int NREQ       = 4;
  localparam int TICK_DIV   = 4;
  localparam int GAP_CYCLES = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  bg_value;
  logic         bg_on;
  logic [3:0]   req_valid;
  logic [127:0] req_value;
  logic [31:0]  req_dwell;
  logic [3:0]   req_ready;
  logic [31:0]  disp_value;
  logic         disp_on;
  logic         busy;
  logic [2:0]   cur_owner;

  int errors = 0;
  int checks = 0;

  logic [40:0] exp_v;
  wire  [40:0] obs = {disp_value, disp_on, busy, cur_owner, req_ready};

  logic [31:0] rr_vals [4] = '{32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003};

  seg_display_arbiter #(
    .NREQ       (NREQ),
    .TICK_DIV   (TICK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bg_value   (bg_value),
    .bg_on      (bg_on),
    .req_valid  (req_valid),
    .req_value  (req_value),
    .req_dwell  (req_dwell),
    .req_ready  (req_ready),
    .disp_value (disp_value),
    .disp_on    (disp_on),
    .busy       (busy),
    .cur_owner  (cur_owner)
  );

  always #5 clk = ~clk;

  // Expected display enable for SHOW cycle k (0-based) of a message with this dwell.
  function automatic logic exp_show_on(input int dwell, input int k);
    int rem;
    bit blink;
    rem   = dwell - (k / TICK_DIV);
    blink = 1'b0;
`ifdef SEG_ARB_BLINK_EN
    blink = 1'b1;
`endif
    if (blink && rem <= 2) return ((k % TICK_DIV) < (TICK_DIV / 2));
    return 1'b1;
  endfunction

  task test_reset;
    rst_n     = 1'b0;
    bg_value  = 32'hCAFE_0000;
    bg_on     = 1'b1;
    req_valid = 4'b0001;
    req_value = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    req_dwell = 32'h0000_0002;
    repeat (2) @(negedge clk);
    #1;
    exp_v = {32'hCAFE_0000, 1'b1, 1'b0, 3'd0, 4'b0000};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL reset_hold got=%h exp=%h", obs, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reset_release_ready got=%b exp=%b", req_ready, 4'b0001);
    end
    repeat (3) @(negedge clk);
    #1;
    exp_v = {32'hAAAA_0000, exp_show_on(2, 2), 1'b1, 3'd0, 4'b0000};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL reset_pre_show got=%h exp=%h", obs, exp_v);
    end
    rst_n = 1'b0;
    #1;
    exp_v = {32'hCAFE_0000, 1'b1, 1'b0, 3'd0, 4'b0000};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL reset_mid_show got=%h exp=%h", obs, exp_v);
    end
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL reset_after got=%h exp=%h", obs, exp_v);
    end
  endtask

  task test_single;
    @(negedge clk);
    req_value[95:64] = 32'h0000_1234;
    req_dwell[23:16] = 8'd3;
    req_valid        = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL single_ready got=%b exp=%b", req_ready, 4'b0100);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 4'b0000;
      #1;
      exp_v = {32'h0000_1234, exp_show_on(3, k), 1'b1, 3'd2, 4'b0000};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL single_show k=%0d got=%h exp=%h", k, obs, exp_v);
      end
    end
    for (int g = 0; g < GAP_CYCLES; g++) begin
      @(negedge clk);
      #1;
      exp_v = {32'h0000_1234, 1'b0, 1'b1, 3'd2, 4'b0000};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL single_gap g=%0d got=%h exp=%h", g, obs, exp_v);
      end
    end
    @(negedge clk);
    #1;
    exp_v = {32'hCAFE_0000, 1'b1, 1'b0, 3'd0, 4'b0000};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL single_idle got=%h exp=%h", obs, exp_v);
    end
  endtask

  task test_bg_idle;
    @(negedge clk);
    bg_value = 32'h0BAD_F00D;
    bg_on    = 1'b0;
    #1;
    checks++;
    if ({disp_value, disp_on} !== {32'h0BAD_F00D, 1'b0}) begin
      errors++;
      $display("[TB] FAIL bg_off got=%h/%b exp=0badf00d/0", disp_value, disp_on);
    end
    bg_value = 32'h1357_9BDF;
    bg_on    = 1'b1;
    #1;
    checks++;
    if ({disp_value, disp_on} !== {32'h1357_9BDF, 1'b1}) begin
      errors++;
      $display("[TB] FAIL bg_on got=%h/%b exp=13579bdf/1", disp_value, disp_on);
    end
  endtask

  task test_dwell_zero;
    @(negedge clk);
    req_dwell[15:8] = 8'd0;
    req_valid       = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL dwell0_ready got=%b exp=%b", req_ready, 4'b0010);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 4'b0000;
      #1;
      exp_v = {32'hBBBB_0001, exp_show_on(1, k), 1'b1, 3'd1, 4'b0000};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL dwell0_show k=%0d got=%h exp=%h", k, obs, exp_v);
      end
    end
    @(negedge clk);
    #1;
    exp_v = {32'hBBBB_0001, 1'b0, 1'b1, 3'd1, 4'b0000};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL dwell0_end got=%h exp=%h", obs, exp_v);
    end
    repeat (2) @(negedge clk);
    #1;
    exp_v = {32'h1357_9BDF, 1'b1, 1'b0, 3'd0, 4'b0000};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL dwell0_idle got=%h exp=%h", obs, exp_v);
    end
  endtask

  task test_round_robin;
    int owner;
    @(negedge clk);
    rst_n = 1'b0;
    req_value = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    req_dwell = 32'h0101_0101;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int m = 0; m < 5; m++) begin
      owner = m % 4;
      checks++;
      if (req_ready !== 4'(1 << owner)) begin
        errors++;
        $display("[TB] FAIL rr_grant m=%0d got=%b exp=%b", m, req_ready, 4'(1 << owner));
      end
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (m == 4 && k == 0) req_valid = 4'b0000;
        #1;
        exp_v = {rr_vals[owner], exp_show_on(1, k), 1'b1, 3'(owner), 4'b0000};
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("[TB] FAIL rr_show m=%0d k=%0d got=%h exp=%h", m, k, obs, exp_v);
        end
      end
      for (int g = 0; g < GAP_CYCLES; g++) begin
        @(negedge clk);
        #1;
        checks++;
        if ({disp_on, busy, req_ready} !== {1'b0, 1'b1, 4'b0000}) begin
          errors++;
          $display("[TB] FAIL rr_gap m=%0d g=%0d got=%b%b%b exp=010000", m, g, disp_on, busy, req_ready);
        end
      end
      @(negedge clk);
      #1;
    end
    exp_v = {32'h1357_9BDF, 1'b1, 1'b0, 3'd0, 4'b0000};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL rr_idle got=%h exp=%h", obs, exp_v);
    end
  endtask

  task test_late_withdraw;
    @(negedge clk);
    req_dwell[7:0] = 8'd2;
    req_valid      = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL late_ready got=%b exp=%b", req_ready, 4'b0001);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 4'b0000;
      if (k == 2) req_valid = 4'b1000;
      if (k == 3) req_value[31:0] = 32'hFFFF_FFFF;
      if (k == 5) req_valid = 4'b0000;
      #1;
      exp_v = {32'hAAAA_0000, exp_show_on(2, k), 1'b1, 3'd0, 4'b0000};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL late_show k=%0d got=%h exp=%h", k, obs, exp_v);
      end
    end
    for (int c = 0; c < GAP_CYCLES + 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL late_no_grant c=%0d got=%b exp=0000", c, req_ready);
      end
    end
    exp_v = {32'h1357_9BDF, 1'b1, 1'b0, 3'd0, 4'b0000};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL late_idle got=%h exp=%h", obs, exp_v);
    end
  endtask

  task test_blink;
    @(negedge clk);
    req_dwell[23:16] = 8'd4;
    req_valid        = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL blink_ready got=%b exp=%b", req_ready, 4'b0100);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 4'b0000;
      #1;
      exp_v = {32'hCCCC_0002, exp_show_on(4, k), 1'b1, 3'd2, 4'b0000};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL blink_show k=%0d got=%h exp=%h", k, obs, exp_v);
      end
    end
    repeat (GAP_CYCLES + 1) @(negedge clk);
    #1;
    exp_v = {32'h1357_9BDF, 1'b1, 1'b0, 3'd0, 4'b0000};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("[TB] FAIL blink_idle got=%h exp=%h", obs, exp_v);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_bg_idle;
    test_dwell_zero;
    test_round_robin;
    test_late_withdraw;
    test_blink;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
